// File: rtl/redux_pkg.sv
// Shared types and encodings for the Redux-V multi-cycle control unit.
package redux_pkg;

  localparam logic [3:0] OpBrzr  = 4'h0;
  localparam logic [3:0] OpJi    = 4'h1;
  localparam logic [3:0] OpLd    = 4'h2;
  localparam logic [3:0] OpSt    = 4'h3;
  localparam logic [3:0] OpAluLo = 4'h4;
  localparam logic [3:0] OpAluHi = 4'hA;
  localparam logic [3:0] OpLi    = 4'hB;
  localparam logic [3:0] OpHalt  = 4'hF;

  typedef enum logic [2:0] {StFetch, StDecode, StExec, StMem, StWb, StHalt} state_e;

  typedef enum logic [2:0] {
    ClsBrzr, ClsJi, ClsLd, ClsSt, ClsAlu, ClsLi, ClsNop, ClsHalt
  } op_class_e;

  localparam logic [2:0] AluAdd = 3'd0;
  localparam logic [2:0] AluSub = 3'd1;
  localparam logic [2:0] AluAnd = 3'd2;
  localparam logic [2:0] AluOr  = 3'd3;
  localparam logic [2:0] AluNot = 3'd4;
  localparam logic [2:0] AluShl = 3'd5;
  localparam logic [2:0] AluShr = 3'd6;

  localparam logic [1:0] WselAlu = 2'b00;
  localparam logic [1:0] WselMem = 2'b01;
  localparam logic [1:0] WselImm = 2'b10;

endpackage

// File: rtl/redux_ctrl_if.sv
// Control-unit bus: instruction fetch, register-file and data-memory control signals.
interface redux_ctrl_if #(
  parameter int unsigned PC_W = 8
);
  logic [7:0]      imem_data;
  logic [7:0]      reg_a_val;
  logic [7:0]      reg_b_val;
  logic [PC_W-1:0] pc;
  logic [1:0]      reg_a;
  logic [1:0]      reg_b;
  logic [1:0]      write_addr;
  logic            write_enable;
  logic [1:0]      write_sel;
  logic [2:0]      alu_op;
  logic            mem_read;
  logic            mem_write;
  logic            halted;

  modport master (
    input  imem_data, reg_a_val, reg_b_val,
    output pc, reg_a, reg_b, write_addr, write_enable, write_sel, alu_op,
           mem_read, mem_write, halted
  );

  modport slave (
    output imem_data, reg_a_val, reg_b_val,
    input  pc, reg_a, reg_b, write_addr, write_enable, write_sel, alu_op,
           mem_read, mem_write, halted
  );
endinterface

// File: rtl/redux_decode.sv
// Combinational opcode decode: instruction class, ALU function and writeback source.
module redux_decode
  import redux_pkg::*;
(
  input  logic [3:0] opcode,
  output op_class_e  op_class,
  output logic [2:0] alu_op,
  output logic [1:0] write_sel
);

  always_comb begin
    op_class  = ClsNop;
    alu_op    = AluAdd;
    write_sel = WselAlu;
    if (opcode >= OpAluLo && opcode <= OpAluHi) begin
      op_class = ClsAlu;
      // opcode - 4 taken modulo 8 equals the low three bits minus 4
      alu_op   = opcode[2:0] - 3'd4;
    end else begin
      case (opcode)
        OpBrzr: op_class = ClsBrzr;
        OpJi:   op_class = ClsJi;
        OpLd: begin
          op_class  = ClsLd;
          write_sel = WselMem;
        end
        OpSt:   op_class = ClsSt;
        OpLi: begin
          op_class  = ClsLi;
          write_sel = WselImm;
        end
        OpHalt: op_class = ClsHalt;
        default: op_class = ClsNop;
      endcase
    end
  end

endmodule

// File: rtl/redux_ctrl.sv
// Redux-V multi-cycle control FSM with PC and IR.
// Optional single-step gating of FETCH under REDUX_CTRL_SINGLE_STEP_EN.
module redux_ctrl
  import redux_pkg::*;
#(
  parameter int unsigned PC_W = 8
) (
  input logic          clk,
  input logic          rst,
`ifdef REDUX_CTRL_SINGLE_STEP_EN
  input logic          step,
`endif
  redux_ctrl_if.master bus
);

  state_e          state_q, state_d;
  logic [7:0]      ir_q;
  logic [PC_W-1:0] pc_q, pc_d;
  logic [PC_W-1:0] ji_off;
  logic            we_q, mr_q, mw_q, halted_q;
  op_class_e       op_class;
  logic [2:0]      alu_op;
  logic [1:0]      write_sel;

  redux_decode u_decode (
    .opcode    (ir_q[7:4]),
    .op_class  (op_class),
    .alu_op    (alu_op),
    .write_sel (write_sel)
  );

  assign ji_off = {{(PC_W-4){ir_q[3]}}, ir_q[3:0]};

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    case (state_q)
      StFetch: begin
`ifdef REDUX_CTRL_SINGLE_STEP_EN
        if (step) begin
`else
        begin
`endif
          state_d = StDecode;
          pc_d    = pc_q + PC_W'(1);
        end
      end
      StDecode: begin
        case (op_class)
          ClsLd, ClsSt: state_d = StMem;
          ClsNop:       state_d = StFetch;
          ClsHalt:      state_d = StHalt;
          default:      state_d = StExec;
        endcase
      end
      StExec: begin
        case (op_class)
          ClsBrzr: begin
            if (bus.reg_a_val == 8'd0) pc_d = PC_W'(bus.reg_b_val);
            state_d = StFetch;
          end
          ClsJi: begin
            // offset applies to the pc already advanced by FETCH
            pc_d    = pc_q + ji_off;
            state_d = StFetch;
          end
          default: state_d = StWb;
        endcase
      end
      StMem:   state_d = (op_class == ClsLd) ? StWb : StFetch;
      StWb:    state_d = StFetch;
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  // Strobes are registered from the next state so they track state exactly
  // and clear asynchronously with rst.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StFetch;
      pc_q     <= '0;
      ir_q     <= '0;
      we_q     <= 1'b0;
      mr_q     <= 1'b0;
      mw_q     <= 1'b0;
      halted_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      if (state_q == StFetch && state_d == StDecode) ir_q <= bus.imem_data;
      we_q     <= (state_d == StWb);
      mr_q     <= (state_d == StMem) && (op_class == ClsLd);
      mw_q     <= (state_d == StMem) && (op_class == ClsSt);
      halted_q <= (state_d == StHalt);
    end
  end

  assign bus.pc           = pc_q;
  assign bus.reg_a        = ir_q[3:2];
  assign bus.reg_b        = ir_q[1:0];
  assign bus.write_addr   = ir_q[3:2];
  assign bus.write_enable = we_q;
  assign bus.write_sel    = write_sel;
  assign bus.alu_op       = alu_op;
  assign bus.mem_read     = mr_q;
  assign bus.mem_write    = mw_q;
  assign bus.halted       = halted_q;

endmodule

// File: tb/tb_redux_ctrl.sv
// Bench for redux_ctrl: ISA-level model plus register file, data memory and ALU around the DUT.
module tb_redux_ctrl;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  redux_ctrl_if #(.PC_W(8)) bus ();

`ifdef REDUX_CTRL_SINGLE_STEP_EN
  logic step = 1'b1;
`endif

  redux_ctrl #(.PC_W(8)) dut (
    .clk  (clk),
    .rst  (rst),
`ifdef REDUX_CTRL_SINGLE_STEP_EN
    .step (step),
`endif
    .bus  (bus)
  );

  logic [7:0] imem [256];
  logic [7:0] dmem [256];
  logic [7:0] env_r [4];
  logic [7:0] mdr;

  assign bus.imem_data = imem[bus.pc];
  assign bus.reg_a_val = env_r[bus.reg_a];
  assign bus.reg_b_val = env_r[bus.reg_b];

  // ISA-level model state
  logic [7:0] mdl_r [4];
  logic [7:0] mdl_dmem [256];
  logic [7:0] mpc, mir;
  int         phase;
  bit         mhalt;

  // environment actions sampled mid-cycle, applied after the edge
  bit         p_we, p_mw, p_mr;
  logic [1:0] p_wa;
  logic [7:0] p_wd, p_ma, p_md, p_ra;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [7:0] env_alu(input logic [2:0] f, input logic [7:0] a,
                                         input logic [7:0] b);
    case (f)
      3'd0:    return a + b;
      3'd1:    return a - b;
      3'd2:    return a & b;
      3'd3:    return a | b;
      3'd4:    return ~a;
      3'd5:    return a << 1;
      3'd6:    return a >> 1;
      default: return 8'hxx;
    endcase
  endfunction

  function automatic logic [7:0] isa_alu(input logic [3:0] op, input logic [7:0] a,
                                         input logic [7:0] b);
    if (op == 4'h4) return a + b;
    if (op == 4'h5) return a - b;
    if (op == 4'h6) return a & b;
    if (op == 4'h7) return a | b;
    if (op == 4'h8) return ~a;
    if (op == 4'h9) return a << 1;
    return a >> 1;
  endfunction

  function automatic int cpi(input logic [3:0] op);
    if (op <= 4'h1 || op == 4'h3) return 3;
    if (op >= 4'hC) return 2;
    return 4;
  endfunction

  task automatic check_cycle();
    logic [3:0] op;
    logic [3:0] d;
    bit         is_alu, writes;
    logic       e_we, e_mr, e_mw;
    op     = mir[7:4];
    d      = op - 4'd4;
    is_alu = (op >= 4'h4 && op <= 4'hA);
    writes = is_alu || op == 4'h2 || op == 4'hB;
    e_we   = !mhalt && phase == 3 && writes;
    e_mr   = !mhalt && phase == 2 && op == 4'h2;
    e_mw   = !mhalt && phase == 2 && op == 4'h3;
    check("cycle_pc_strobes",
          {bus.pc, bus.write_enable, bus.mem_read, bus.mem_write, bus.halted},
          {mpc, e_we, e_mr, e_mw, mhalt});
    if (phase >= 1 && !mhalt) begin
      check("reg_addrs", {bus.reg_a, bus.reg_b, bus.write_addr}, {mir[3:2], mir[1:0], mir[3:2]});
      if (is_alu) check("alu_op", bus.alu_op, d[2:0]);
      if (writes) check("write_sel", bus.write_sel, is_alu ? 2'b00 : (op == 4'h2 ? 2'b01 : 2'b10));
    end
  endtask

  task automatic sample_env();
    p_we = bus.write_enable;
    p_wa = bus.write_addr;
    case (bus.write_sel)
      2'b00:   p_wd = env_alu(bus.alu_op, bus.reg_a_val, bus.reg_b_val);
      2'b01:   p_wd = mdr;
      2'b10:   p_wd = {6'b0, bus.reg_b};
      default: p_wd = 8'hxx;
    endcase
    p_mw = bus.mem_write;
    p_ma = bus.reg_b_val;
    p_md = bus.reg_a_val;
    p_mr = bus.mem_read;
    p_ra = bus.reg_b_val;
  endtask

  task automatic apply_env();
    if (p_we) env_r[p_wa] = p_wd;
    if (p_mw) dmem[p_ma] = p_md;
    if (p_mr) mdr = dmem[p_ra];
  endtask

  task automatic retire();
    logic [1:0] ra, rb;
    logic [3:0] op;
    logic [7:0] a;
    ra = mir[3:2];
    rb = mir[1:0];
    op = mir[7:4];
    if (op == 4'h0) begin
      if (mdl_r[ra] == 8'd0) mpc = mdl_r[rb];
    end else if (op == 4'h1) begin
      mpc = mpc + {{4{mir[3]}}, mir[3:0]};
    end else if (op == 4'h2) begin
      mdl_r[ra] = mdl_dmem[mdl_r[rb]];
    end else if (op == 4'h3) begin
      a = mdl_r[rb];
      mdl_dmem[a] = mdl_r[ra];
      check("st_mem", dmem[a], mdl_dmem[a]);
    end else if (op <= 4'hA) begin
      mdl_r[ra] = isa_alu(op, mdl_r[ra], mdl_r[rb]);
    end else if (op == 4'hB) begin
      mdl_r[ra] = {6'b0, rb};
    end
    check("regs", {env_r[0], env_r[1], env_r[2], env_r[3]},
          {mdl_r[0], mdl_r[1], mdl_r[2], mdl_r[3]});
  endtask

  task automatic model_step();
    if (mhalt) return;
    if (phase == 0) begin
      mir   = imem[mpc];
      mpc   = mpc + 8'd1;
      phase = 1;
    end else if (mir[7:4] == 4'hF) begin
      mhalt = 1'b1;
      phase = 2;
    end else begin
      phase++;
      if (phase == cpi(mir[7:4])) begin
        retire();
        phase = 0;
      end
    end
  endtask

  task automatic model_reset();
    mpc   = 8'd0;
    mir   = 8'd0;
    phase = 0;
    mhalt = 1'b0;
  endtask

  task automatic tick();
    check_cycle();
    sample_env();
    @(posedge clk);
    #1;
    apply_env();
    model_step();
    @(negedge clk);
  endtask

  task automatic clear();
    for (int i = 0; i < 256; i++) begin
      imem[i] = 8'hC0;
      dmem[i] = 8'h00;
    end
    for (int i = 0; i < 4; i++) env_r[i] = 8'h00;
  endtask

  task automatic start();
    mdl_r    = env_r;
    mdl_dmem = dmem;
    mdr      = 8'h00;
    rst      = 1'b1;
    @(negedge clk);
    check("reset_outputs", {bus.pc, bus.write_enable, bus.mem_read, bus.mem_write, bus.halted},
          32'd0);
    rst = 1'b0;
    model_reset();
  endtask

  initial begin
    // add r1,r2
    clear();
    imem[0] = 8'h46;
    env_r[1] = 8'd3;
    env_r[2] = 8'd4;
    start();
    for (int i = 1; i <= 4; i++) begin
      check("add_we_cycle", bus.write_enable, (i == 4) ? 1 : 0);
      tick();
    end
    check("add_r1", env_r[1], 8'd7);
    check("add_pc", bus.pc, 8'd1);

    // reset asserted during WB abandons the write
    clear();
    imem[0] = 8'h46;
    env_r[1] = 8'd3;
    env_r[2] = 8'd4;
    start();
    repeat (3) tick();
    check_cycle();
    rst = 1'b1;
    #1;
    check("rstwb_we", bus.write_enable, 1'b0);
    check("rstwb_pc", bus.pc, 8'd0);
    sample_env();
    @(posedge clk);
    #1;
    apply_env();
    check("rstwb_r1", env_r[1], 8'd3);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    repeat (5) tick();
    check("rstwb_rerun_r1", env_r[1], 8'd7);

    // brzr r3,r0 taken and not taken
    clear();
    imem[0] = 8'h0C;
    env_r[0] = 8'h20;
    start();
    repeat (3) tick();
    check("brzr_taken_pc", bus.pc, 8'h20);
    env_r[3] = 8'd5;
    start();
    repeat (3) tick();
    check("brzr_not_taken_pc", bus.pc, 8'h01);

    // ji -1 at 0xFF, wrapping through 0x00
    clear();
    imem[0] = 8'h0C;
    imem[8'hFF] = 8'h1F;
    env_r[0] = 8'hFF;
    start();
    repeat (3) tick();
    check("ji_reach_ff", bus.pc, 8'hFF);
    tick();
    check("ji_fetch_wrap", bus.pc, 8'h00);
    repeat (2) tick();
    check("ji_target", bus.pc, 8'hFF);

    // ld / st / li / ALU program ending in halt
    clear();
    imem[0]  = 8'h29; imem[1]  = 8'h39; imem[2]  = 8'h3E; imem[3]  = 8'hB7;
    imem[4]  = 8'h5B; imem[5]  = 8'h68; imem[6]  = 8'h7D; imem[7]  = 8'h80;
    imem[8]  = 8'h9C; imem[9]  = 8'hA0; imem[10] = 8'h45; imem[11] = 8'hD0;
    imem[12] = 8'hF0;
    env_r[0] = 8'h81;
    env_r[1] = 8'h10;
    env_r[3] = 8'h5A;
    dmem[8'h10] = 8'hA5;
    start();
    repeat (52) tick();
    check("prog_st1_mem", dmem[8'h10], 8'hA5);
    check("prog_st2_mem", dmem[8'hA5], 8'h5A);
    check("prog_regs", {env_r[0], env_r[1], env_r[2], env_r[3]}, 32'h3F0601B6);
    check("prog_halted", bus.halted, 1'b1);

    // halt freezes pc
    clear();
    imem[0] = 8'hF0;
    start();
    repeat (2) tick();
    check("halt_cycle3", bus.halted, 1'b1);
    repeat (20) tick();
    check("halt_pc_frozen", bus.pc, 8'd1);

`ifdef REDUX_CTRL_SINGLE_STEP_EN
    clear();
    step = 1'b0;
    start();
    repeat (10) @(negedge clk);
    check("step_hold_pc", bus.pc, 8'd0);
    step = 1'b1;
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/redux_ctrl.md
Name: redux_ctrl

Overview:
- Multi-cycle control unit for the Redux-V 8-bit core; sits directly upstream of the 4×8-bit register file.
- Fetches one 8-bit instruction per pass from instruction memory and holds it in an instruction register (IR).
- Sequences FETCH/DECODE/EXEC/MEM/WB and drives register-file read addresses, write address/enable, ALU op, writeback mux select, data-memory strobes and the PC.

Parameters:
- PC_W, 8, program-counter width; all PC arithmetic is modulo 2^PC_W.

Ports:
- clk  in  1  single clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- imem_data  in  8  instruction word at address pc, combinational.
- reg_a_val  in  8  register-file output a, i.e. R[reg_a].
- reg_b_val  in  8  register-file output b, i.e. R[reg_b].
- pc  out  PC_W  program counter.
- reg_a  out  2  register-file read address a = IR[3:2].
- reg_b  out  2  register-file read address b = IR[1:0].
- write_addr  out  2  register-file write address = IR[3:2].
- write_enable  out  1  register-file write strobe.
- write_sel  out  2  writeback mux select: 00 ALU, 01 data memory, 10 immediate {6'b0, IR[1:0]}.
- alu_op  out  3  ALU function: 000 add, 001 sub, 010 and, 011 or, 100 not, 101 shl, 110 shr.
- mem_read  out  1  data-memory read strobe; address R[rb].
- mem_write  out  1  data-memory write strobe; address R[rb], data R[ra].
- halted  out  1  core stopped.

Behaviour:
- Reset (async): state=FETCH, pc=0, IR=0, halted=0.
- Strobes write_enable, mem_read, mem_write are decoded from state only (Moore), so they drop in the same instant rst rises.
- Reset mid-operation abandons the instruction; no write occurs.
- Opcodes on IR[7:4]:
  - 0000 brzr: if R[ra]==0 then pc<=R[rb].
  - 0001 ji: pc<=pc+sext(IR[3:0]).
  - 0010 ld: R[ra]<=M[R[rb]].
  - 0011 st: M[R[rb]]<=R[ra].
  - 0100–1010 ALU ops: R[ra]<=R[ra] op R[rb]; alu_op = IR[7:4]-4.
  - 1011 li: R[ra]<={6'b0, rb}.
  - 1100–1110: NOP.
  - 1111 halt.
- FETCH:
  - IR<=imem_data; pc<=pc+1, wrapping 0xFF→0x00.
  - Next state DECODE.
- DECODE:
  - reg_a/reg_b are valid (driven continuously from IR).
  - Next state: MEM for ld/st; FETCH for NOP; HALT for halt; otherwise EXEC.
- EXEC:
  - alu_op is valid.
  - brzr: sample reg_a_val; if zero, pc<=reg_b_val[PC_W-1:0]; next FETCH.
  - ji: pc<=pc+sext (offset relative to the already-incremented pc); next FETCH.
  - ALU and li: next WB.
- MEM:
  - ld: mem_read=1; next WB.
  - st: mem_write=1; next FETCH.
- WB:
  - write_enable=1 for exactly one cycle.
  - write_sel per opcode: ALU=00, ld=01, li=10.
  - Next FETCH.
- HALT:
  - halted=1; all strobes 0; pc frozen. Exited only by rst.
- Cycles per instruction: ALU/li 4; ld 4; st 3; brzr/ji 3; NOP 2.
- write_addr, write_sel and alu_op are held stable from DECODE until the next FETCH.
- Outside their active states all strobes are 0.

Optional Feature:
- Macro: REDUX_CTRL_SINGLE_STEP_EN.
- Defined:
  - Adds input step (1 bit).
  - FETCH holds (no IR load, no pc increment) until step==1 is sampled.
  - One instruction executes per step pulse; a step held high runs continuously.
- Undefined:
  - No step port; FETCH always advances.

Decomposition:
- Package redux_pkg holds:
  - opcode constants;
  - state enum (FETCH, DECODE, EXEC, MEM, WB, HALT);
  - alu_op codes;
  - write_sel codes.
- Sub-module redux_decode (combinational): maps IR to opcode class, alu_op and write_sel.
- The FSM and PC/IR registers stay in redux_ctrl.

Test Plan:
- rst asserted mid-WB of add -> write_enable=0 immediately; pc=0, state FETCH, no register write.
- imem[0]=0x46 (add r1,r2), R1=3, R2=4 -> write_enable high on cycle 4 only; write_addr=1, alu_op=000, write_sel=00; pc=1.
- imem[0]=0x0C (brzr r3,r0), R3=0, R0=0x20 -> pc=0x20 after cycle 3; with R3=5 -> pc=1.
- pc=0xFF, imem[0xFF]=0x1F (ji -1) -> fetch increments pc to 0x00; EXEC sets pc=0xFF.
- ld 0x29 then st 0x39 -> ld: mem_read 1 cycle then write_enable with write_sel=01; st: mem_write 1 cycle, no write_enable.
- imem[0]=0xF0 -> halted=1 from cycle 3; pc stays 1 for 20 cycles. With REDUX_CTRL_SINGLE_STEP_EN and step=0, pc stays 0 indefinitely.
